jtag_tdo_capture: RTL and testbench

JTAG_TDO_CAPTURE -- requirements
Module: jtag_tdo_capture

---
 rtl/jtag_pkg.sv | 19 +
 rtl/jtag_tck_edge.sv | 20 ++
 rtl/jtag_tdo_capture.sv | 132 +++++++++++++
 tb/tb_jtag_tdo_capture.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared types for the JTAG TDO capture block: capture FSM states and debug view.
package jtag_pkg;

    localparam int DATA_FIFO_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } cap_state_e;

    typedef struct packed {
        cap_state_e state;
        logic       pend;
        logic       tck_rise;
        logic       tck_fall;
    } cap_dbg_t;

endpackage

// File: rtl/jtag_tck_edge.sv
// Registers the engine's tck (already in the clk domain) and flags its edges.
module jtag_tck_edge (
    input  logic clk,
    input  logic rst,
    input  logic tck_i,
    output logic rise_o,
    output logic fall_o
);

    logic tck_q;

    always_ff @(posedge clk) begin
        if (rst) tck_q <= 1'b0;
        else     tck_q <= tck_i;
    end

    assign rise_o = tck_i & ~tck_q;
    assign fall_o = ~tck_i & tck_q;

endmodule

// File: rtl/jtag_tdo_capture.sv
// Deserialises TDO LSB-first into DATA_FIFO-bit words and pushes them to a result
// FIFO through a one-deep pending register; overflow is sticky when a word is dropped.
module jtag_tdo_capture
    import jtag_pkg::*;
#(
    parameter int DATA_FIFO = DATA_FIFO_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tck,
    input  logic                 tdo,
    input  logic                 shift_en,
    input  logic                 shift_last,
    input  logic                 full,
    output logic [DATA_FIFO-1:0] wdata,
    output logic                 wr,
    output logic                 done,
    output logic                 overflow,
    input  logic                 clear_stat,
    output logic [CNT_W-1:0]     bits_captured,
    output cap_dbg_t             dbg
);

    localparam int IW = (DATA_FIFO > 1) ? $clog2(DATA_FIFO) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_FIFO - 1);

    cap_state_e           state_q, state_d;
    logic [DATA_FIFO-1:0] sreg_q, sreg_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_base;
    logic                 pend_q, pend_d;
    logic [DATA_FIFO-1:0] pword_q, pword_d;
    logic                 ovf_q, ovf_d;
    logic                 tck_rise, tck_fall;
    logic                 sample, complete, wr_fire;
    logic [DATA_FIFO-1:0] word;

    jtag_tck_edge u_tck_edge (
        .clk    (clk),
        .rst    (rst),
        .tck_i  (tck),
        .rise_o (tck_rise),
        .fall_o (tck_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pword_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pword_q <= pword_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        pword_d  = pword_q;
        ovf_d    = ovf_q;
        // A tck rise that lands in S_DONE belongs to no scan and is ignored.
        sample   = tck_rise & shift_en & (state_q != S_DONE);
        complete = sample & ((idx_q == LAST_IDX) | shift_last);
        wr_fire  = pend_q & ~full;
        word     = sreg_q;
        word[idx_q] = tdo;

        case (state_q)
            S_IDLE:  if (shift_en) state_d = (sample && shift_last) ? S_DONE : S_SHIFT;
            S_SHIFT: begin
                if (sample && shift_last) state_d = S_DONE;
                else if (!shift_en)       state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cnt_base = (state_q == S_IDLE && shift_en) ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (sample && cnt_base != '1) cnt_d = cnt_base + 1'b1;

        if (sample) begin
            if (complete) begin
                sreg_d = '0;
                idx_d  = '0;
            end else begin
                sreg_d = word;
                idx_d  = idx_q + 1'b1;
            end
        end else if (!shift_en) begin
            sreg_d = '0;
            idx_d  = '0;
        end

        if (wr_fire) pend_d = 1'b0;
        if (clear_stat) ovf_d = 1'b0;
        // Drop wins over clear_stat; a word completing on the write cycle refills pend.
        if (complete) begin
            if (pend_q && !wr_fire) begin
                ovf_d = 1'b1;
            end else begin
                pend_d  = 1'b1;
                pword_d = word;
            end
        end
    end

    assign wr            = pend_q & ~full & ~rst;
    assign wdata         = pword_q;
    assign done          = (state_q == S_DONE);
    assign overflow      = ovf_q;
    assign bits_captured = cnt_q;

    assign dbg.state    = state_q;
    assign dbg.pend     = pend_q;
    assign dbg.tck_rise = tck_rise;
    assign dbg.tck_fall = tck_fall;

endmodule

// File: tb/tb_jtag_tdo_capture.sv
// Self-checking bench for jtag_tdo_capture: scan scenarios with a queue of expected FIFO words.
module tb_jtag_tdo_capture;
    import jtag_pkg::*;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tck = 1'b0;
    logic          tdo = 1'b0;
    logic          shift_en = 1'b0;
    logic          shift_last = 1'b0;
    logic          full = 1'b0;
    logic          clear_stat = 1'b0;
    logic [DW-1:0] wdata;
    logic          wr;
    logic          done;
    logic          overflow;
    logic [CW-1:0] bits_captured;
    cap_dbg_t      dbg;

    int            tests_run = 0;
    int            tests_failed = 0;
    int            wr_cnt = 0;
    int            done_cnt = 0;
    logic          done_after_last = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_w;

    always #5 clk = ~clk;

    jtag_tdo_capture #(.DATA_FIFO(DW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .tck           (tck),
        .tdo           (tdo),
        .shift_en      (shift_en),
        .shift_last    (shift_last),
        .full          (full),
        .wdata         (wdata),
        .wr            (wr),
        .done          (done),
        .overflow      (overflow),
        .clear_stat    (clear_stat),
        .bits_captured (bits_captured),
        .dbg           (dbg)
    );

    // Scoreboard: every FIFO write is matched against the oldest expected word.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            wr_cnt++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL wr_unexpected: wdata=%h, required no write", wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (wdata !== exp_w) begin
                    tests_failed++;
                    $display("FAIL wr_data: wdata=%h, required %h", wdata, exp_w);
                end
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Two clk cycles per bit; the rise is sampled on the second edge.
    task automatic jtag_bit(input logic d, input logic last, input logic clr);
        @(posedge clk); #1;
        tdo = d; shift_last = last; clear_stat = clr; tck = 1'b1;
        @(posedge clk); #1;
        done_after_last = done;
        tck = 1'b0; shift_last = 1'b0; clear_stat = 1'b0;
        tdo = 1'($urandom_range(0, 1));
        if (last) shift_en = 1'b0;
    endtask

    task automatic scan(input logic [31:0] bits, input int n, input logic flag_last, input logic clr_on_last);
        @(posedge clk); #1;
        shift_en = 1'b1;
        for (int i = 0; i < n; i++)
            jtag_bit(bits[i], flag_last && (i == n - 1), clr_on_last && (i == n - 1));
        if (!flag_last) begin
            @(posedge clk); #1;
            shift_en = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        idle(3);
        tests_run++;
        if (wr !== 1'b0 || wdata !== '0 || done !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: wr=%b wdata=%h done=%b ovf=%b, required 0", wr, wdata, done, overflow);
        end
        tests_run++;
        if (bits_captured !== '0 || dbg.state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: bits=%0d state=%0d, required 0/IDLE", bits_captured, dbg.state);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_scan8();
        int d0;
        d0 = done_cnt;
        exp_q.push_back(8'h4D);
        scan(32'h4D, 8, 1'b1, 1'b0);
        tests_run++;
        if (done_after_last !== 1'b1) begin
            tests_failed++;
            $display("FAIL scan8_done_timing: done=%b one cycle after last sample, required 1", done_after_last);
        end
        idle(3);
        wait_drain();
        tests_run++;
        if (done_cnt - d0 != 1) begin
            tests_failed++;
            $display("FAIL scan8_done_count: %0d pulses, required 1", done_cnt - d0);
        end
        tests_run++;
        if (bits_captured !== 4'd8) begin
            tests_failed++;
            $display("FAIL scan8_bits: %0d, required 8", bits_captured);
        end
    endtask

    task automatic test_scan12();
        int w0;
        w0 = wr_cnt;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h0F);
        scan(32'hFFF, 12, 1'b1, 1'b0);
        idle(3);
        wait_drain();
        tests_run++;
        if (wr_cnt - w0 != 2 || bits_captured !== 4'd12) begin
            tests_failed++;
            $display("FAIL scan12: writes=%0d bits=%0d, required 2/12", wr_cnt - w0, bits_captured);
        end
    endtask

    task automatic test_full_overflow();
        int w0;
        w0 = wr_cnt;
        full = 1'b1;
        exp_q.push_back(8'hA5);
        scan(32'h3CA5, 16, 1'b1, 1'b0);
        idle(4);
        tests_run++;
        if (overflow !== 1'b1 || wr_cnt != w0 || wdata !== 8'hA5) begin
            tests_failed++;
            $display("FAIL full_hold: ovf=%b writes=%0d wdata=%h, required 1/0/a5", overflow, wr_cnt - w0, wdata);
        end
        tests_run++;
        if (bits_captured !== 4'hF) begin
            tests_failed++;
            $display("FAIL bits_saturate: %0d, required 15", bits_captured);
        end
        full = 1'b0;
        wait_drain();
        idle(4);
        tests_run++;
        if (wr_cnt - w0 != 1) begin
            tests_failed++;
            $display("FAIL full_release: writes=%0d, required 1", wr_cnt - w0);
        end
        clear_stat = 1'b1;
        idle(1);
        clear_stat = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_stat: ovf=%b, required 0", overflow);
        end
    endtask

    task automatic test_abort();
        int w0, d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        scan(32'h15, 5, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            tck = 1'b1; tdo = 1'($urandom_range(0, 1));
            idle(2);
            tck = 1'b0;
            idle(2);
        end
        tests_run++;
        if (wr_cnt != w0 || done_cnt != d0 || dbg.state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL abort: writes=%0d dones=%0d state=%0d, required 0/0/IDLE", wr_cnt - w0, done_cnt - d0, dbg.state);
        end
        tests_run++;
        if (bits_captured !== 4'd5) begin
            tests_failed++;
            $display("FAIL abort_bits: %0d, required 5", bits_captured);
        end
        exp_q.push_back(8'h03);
        scan(32'h3, 3, 1'b1, 1'b0);
        idle(3);
        wait_drain();
        tests_run++;
        if (bits_captured !== 4'd3) begin
            tests_failed++;
            $display("FAIL post_abort_bits: %0d, required 3", bits_captured);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wr_cnt;
        full = 1'b1;
        scan(32'h1234, 16, 1'b1, 1'b1);
        idle(2);
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_over_clear: ovf=%b, required 1", overflow);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        full = 1'b0;
        tests_run++;
        if (wr !== 1'b0 || wdata !== '0 || done !== 1'b0 || overflow !== 1'b0 || bits_captured !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: wr=%b wdata=%h done=%b ovf=%b bits=%0d, required 0",
                     wr, wdata, done, overflow, bits_captured);
        end
        idle(6);
        tests_run++;
        if (wr_cnt != w0 || dbg.state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset_mid_no_wr: writes=%0d state=%0d, required 0/IDLE", wr_cnt - w0, dbg.state);
        end
    endtask

    initial begin
        test_reset();
        test_scan8();
        test_scan12();
        test_full_overflow();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
